conv3x3_pack: RTL and testbench
===============================

Name: conv3x3_pack

Overview:
- Downstream neighbour of the 3x3 window controller.
- Each cycle that in_valid is high, it takes one 3x3 window of 4-bit grayscale pixels plus three kernel rows of signed 4-bit coefficients and computes their dot product in a pipeline.
- Each result is normalised and clamped to 4 bits. Three consecutive results are packed MSB-first into one 12-bit word and written to the output frame BRAM, using the same three-nibbles-per-word layout as the input frame.
- Pulses done after the last word of the frame is written.

Parameters:
- IMG_W, 638, results per output row.
- IMG_H, 478, output rows per frame.
- WORDS_PER_ROW, 213, BRAM words per output row; must equal ceil(IMG_W/3).
- SHIFT, 0, arithmetic right shift applied to the raw sum before clamping (0..7).
- ABS_MODE, 0, 0: negative sums clamp to 0; 1: absolute value of the sum is taken before clamping.

Ports:
- pixel_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  window and kernel inputs valid this cycle.
- pixel1  in  12  window top row, nibbles [11:8],[7:4],[3:0] = left, centre, right; unsigned.
- pixel2  in  12  window middle row, same nibble layout.
- pixel3  in  12  window bottom row, same nibble layout.
- kernel1  in  12  top kernel row, three signed 4-bit coefficients, same nibble order.
- kernel2  in  12  middle kernel row.
- kernel3  in  12  bottom kernel row.
- wr_en  out  1  output BRAM write enable, one-cycle pulse per word.
- wr_addr  out  17  output BRAM word address.
- wr_data  out  12  packed result word; first result in [11:8].
- done  out  1  one-cycle pulse marking frame complete.

Behaviour:
- Reset: rst is synchronous, active-high; clock is pixel_clk.
  - All outputs reset to 0; wr_addr resets to 0.
  - Pipeline valid bits, pack register, nibble index, column counter and row counter all clear.
  - Reset mid-frame abandons the frame: no write and no done is produced for in-flight data.
- Arithmetic:
  - Each product is a 4-bit unsigned pixel times a 4-bit signed coefficient, giving a 9-bit signed value.
  - The sum of 9 products is 12-bit signed (range -1080..945).
  - The shifted value is sum >>> SHIFT (arithmetic).
  - ABS_MODE applies after the shift.
  - The result is clamped to 0..15.
- Pipeline, for an in_valid at cycle N:
  - S1 (N+1): 9 products registered.
  - S2 (N+2): sum registered.
  - S3 (N+3): clamped 4-bit result registered with its valid bit.
  - Pack (N+4): wr_en asserted if this result completes a word.
- in_valid may drop for any number of cycles. Valid bits travel with the data; bubbles produce no writes and never corrupt the pack state.
- Pack state machine, states NIB0, NIB1, NIB2; advances only on an S3-valid result:
  - NIB0: result goes to [11:8], [7:0] clears. If this is the last column, write and stay in NIB0; otherwise go to NIB1.
  - NIB1: result goes to [7:4]. If last column, write with [3:0]=0 and go to NIB0; otherwise go to NIB2.
  - NIB2: result goes to [3:0], write, go to NIB0.
- Column and row counters:
  - The column counter counts valid results 0..IMG_W-1.
  - At the last column, the column counter wraps to 0 and the row counter increments.
  - A partial final word in a row is always flushed at row end; results never span rows.
- Addressing: wr_addr = row*WORDS_PER_ROW + word_index, where word_index restarts at 0 on each row.
- Frame end:
  - The write of the last word of row IMG_H-1 asserts done in the same cycle as that wr_en.
  - Counters and pack state return to reset values on the next cycle; the next valid result starts a new frame at address 0.
- Coincident events: a valid in S1, S2 and S3 at once is normal streaming and must sustain one result per cycle. An input arriving while done pulses belongs to the new frame.

Decomposition:
- Shared package conv_pkg holds:
  - NIB_W=4, WORD_W=12, ADDR_W=17.
  - Default image constants.
  - Pack-state localparams.
  - A clamp function (signed 12-bit in, 4-bit out, with SHIFT/ABS_MODE handling).
- One sub-module, mac3x3: the S1/S2 product and adder-tree pipeline with its valid bits.
- The top level conv3x3_pack holds the clamp stage, pack FSM, counters and address generation.

Test Plan:
1. Laplacian kernel (0x111, 0x181, 0x111), all pixels 0x555, 3 valid cycles -> sum 0, one write: wr_addr 0, wr_data 0x000, at cycle N+4 after the third input.
2. Same kernel, centre 0xF and others 0; ABS_MODE=0 -> result 0x0. With ABS_MODE=1 -> result 0xF (sum -120).
3. Same kernel, centre 0 and others 3; SHIFT=3 -> sum 24, result 0x3. With SHIFT=0 -> result 0xF (saturation clamp).
4. Packing with bubbles: results 1, 2, 3 with in_valid gaps of 0, 2 and 5 cycles -> exactly one write, wr_data 0x123, no extra wr_en.
5. Row flush, IMG_W=638: the row's last word has two results and low nibble 0 at wr_addr 212; the next row's first word goes to wr_addr 213.
6. Small frame, IMG_W=4, IMG_H=2, WORDS_PER_ROW=2 -> writes at addresses 0,1,2,3; the word at 1 and 3 has [7:0]=0; done pulses with the write at 3. Asserting rst mid-row 1 yields no further writes and no done.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, pack-state encoding and the result clamp for conv3x3_pack.
package conv_pkg;
    localparam int NIB_W  = 4;
    localparam int WORD_W = 12;
    localparam int ADDR_W = 17;
    localparam int PROD_W = 9;
    localparam int SUM_W  = 12;

    localparam int DEF_IMG_W         = 638;
    localparam int DEF_IMG_H         = 478;
    localparam int DEF_WORDS_PER_ROW = 213;

    // Which nibble of the output word the next result lands in.
    typedef enum logic [1:0] {
        NIB0 = 2'd0,
        NIB1 = 2'd1,
        NIB2 = 2'd2
    } nib_state_e;

    // Arithmetic shift, optional absolute value, then saturate to 0..15.
    function automatic logic [NIB_W-1:0] clamp_nib(input logic signed [SUM_W-1:0] sum,
                                                   input int unsigned shift,
                                                   input bit abs_mode);
        logic signed [SUM_W-1:0] sh;
        sh = sum >>> shift;
        if (abs_mode && sh[SUM_W-1])
            sh = -sh;
        if (sh[SUM_W-1])
            return '0;
        else if (sh > 12'sd15)
            return 4'hF;
        else
            return sh[NIB_W-1:0];
    endfunction
endpackage

// File: rtl/mac3x3.sv
// 3x3 multiply (S1) and adder tree (S2) with valid bits travelling alongside.
module mac3x3 import conv_pkg::*; (
    input  logic                     pixel_clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WORD_W-1:0]        pixel1,
    input  logic [WORD_W-1:0]        pixel2,
    input  logic [WORD_W-1:0]        pixel3,
    input  logic [WORD_W-1:0]        kernel1,
    input  logic [WORD_W-1:0]        kernel2,
    input  logic [WORD_W-1:0]        kernel3,
    output logic                     sum_valid,
    output logic signed [SUM_W-1:0]  sum
);
    logic [2:0][WORD_W-1:0]    pix_rows;
    logic [2:0][WORD_W-1:0]    ker_rows;
    logic signed [PROD_W-1:0]  prod_d [9];
    logic signed [PROD_W-1:0]  prod_q [9];
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SUM_W-1:0]   sum_q;
    logic [1:0]                vld_q;

    assign pix_rows = {pixel1, pixel2, pixel3};
    assign ker_rows = {kernel1, kernel2, kernel3};

    // Unsigned pixel nibble times signed coefficient nibble, both widened to 9 bits.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[r*3+c] = $signed({5'b0, pix_rows[r][c*NIB_W +: NIB_W]}) *
                                $signed({{5{ker_rows[r][c*NIB_W+NIB_W-1]}}, ker_rows[r][c*NIB_W +: NIB_W]});
            end
        end
    end

    // Sign-extended sum of the nine registered products.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++)
            sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end

    // Data registers for S1/S2; they need no reset because valid gates them.
    always_ff @(posedge pixel_clk) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

    // Valid shift register: bit 0 = S1, bit 1 = S2.
    always_ff @(posedge pixel_clk) begin
        if (rst)
            vld_q <= '0;
        else
            vld_q <= {vld_q[0], in_valid};
    end

    assign sum_valid = vld_q[1];
    assign sum       = sum_q;
endmodule

// File: rtl/conv3x3_pack.sv
// 3x3 convolution: MAC pipeline, clamp stage, 3-nibble packer and BRAM addressing.
module conv3x3_pack import conv_pkg::*; #(
    parameter int IMG_W         = DEF_IMG_W,
    parameter int IMG_H         = DEF_IMG_H,
    parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int SHIFT         = 0,
    parameter int ABS_MODE      = 0
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] pixel1,
    input  logic [WORD_W-1:0] pixel2,
    input  logic [WORD_W-1:0] pixel3,
    input  logic [WORD_W-1:0] kernel1,
    input  logic [WORD_W-1:0] kernel2,
    input  logic [WORD_W-1:0] kernel3,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              done
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WRD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    logic                     sum_vld;
    logic signed [SUM_W-1:0]  sum;
    logic                     res_vld_q;
    logic [NIB_W-1:0]         res_q;
    nib_state_e               state_q;
    logic [WORD_W-1:0]        pack_q;
    logic [COL_W-1:0]         col_q;
    logic [ROW_W-1:0]         row_q;
    logic [WRD_W-1:0]         word_q;
    logic [ADDR_W-1:0]        base_q;
    logic                     last_col;
    logic                     last_row;
    logic                     wr_now;

    mac3x3 u_mac (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .pixel1    (pixel1),
        .pixel2    (pixel2),
        .pixel3    (pixel3),
        .kernel1   (kernel1),
        .kernel2   (kernel2),
        .kernel3   (kernel3),
        .sum_valid (sum_vld),
        .sum       (sum)
    );

    // S3: clamp the raw sum to a nibble and carry its valid bit.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            res_vld_q <= sum_vld;
            res_q     <= clamp_nib(sum, SHIFT, ABS_MODE != 0);
        end
    end

    assign last_col = (col_q == COL_W'(IMG_W-1));
    assign last_row = (row_q == ROW_W'(IMG_H-1));
    // A word is emitted when the third nibble arrives or the row ends early.
    assign wr_now   = res_vld_q && (last_col || state_q == NIB2);

    // Pack FSM plus column/row/word counters; outputs are registered here.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q <= NIB0;
            pack_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            word_q  <= '0;
            base_q  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (res_vld_q) begin
                case (state_q)
                    NIB0: begin
                        pack_q  <= {res_q, 8'h00};
                        wr_data <= last_col ? {res_q, 8'h00} : wr_data;
                        state_q <= last_col ? NIB0 : NIB1;
                    end
                    NIB1: begin
                        pack_q  <= {pack_q[11:8], res_q, 4'h0};
                        wr_data <= last_col ? {pack_q[11:8], res_q, 4'h0} : wr_data;
                        state_q <= last_col ? NIB0 : NIB2;
                    end
                    NIB2: begin
                        pack_q  <= {pack_q[11:4], res_q};
                        wr_data <= {pack_q[11:4], res_q};
                        state_q <= NIB0;
                    end
                    default: state_q <= NIB0;
                endcase

                if (wr_now) begin
                    wr_en   <= 1'b1;
                    wr_addr <= base_q + ADDR_W'(word_q);
                end

                // Row end always flushes, so the word index restarts with the row.
                if (last_col) begin
                    col_q  <= '0;
                    word_q <= '0;
                    if (last_row) begin
                        row_q  <= '0;
                        base_q <= '0;
                        done   <= 1'b1;
                    end else begin
                        row_q  <= row_q + ROW_W'(1);
                        base_q <= base_q + ADDR_W'(WORDS_PER_ROW);
                    end
                end else begin
                    col_q <= col_q + COL_W'(1);
                    if (state_q == NIB2)
                        word_q <= word_q + WRD_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_pack.sv
// Directed bench for conv3x3_pack: four instances (default, ABS, SHIFT=3, small frame).
module tb_conv3x3_pack;
    typedef struct packed {
        logic [16:0] a;
        logic [11:0] d;
        logic        dn;
        logic [31:0] c;
    } wr_t;

    localparam logic [11:0] LK1 = 12'h111, LK2 = 12'h181, LK3 = 12'h111;
    localparam logic [11:0] IK1 = 12'h000, IK2 = 12'h010, IK3 = 12'h000;

    logic             pixel_clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       vin = '0;
    logic [11:0]      pixel1 = '0, pixel2 = '0, pixel3 = '0;
    logic [11:0]      kernel1 = '0, kernel2 = '0, kernel3 = '0;
    logic [3:0]       wen, dn;
    logic [3:0][16:0] wa;
    logic [3:0][11:0] wd;

    int  cyc = 0;
    int  pass_cnt = 0;
    int  tot_cnt = 0;
    int  dn_cnt[4] = '{0, 0, 0, 0};
    int  dn_alone = 0;
    wr_t q0[$], q1[$], q2[$], q3[$];

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    conv3x3_pack u_d0 (
        .pixel_clk(pixel_clk), .rst(rst), .in_valid(vin[0]),
        .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
        .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
        .wr_en(wen[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .done(dn[0]));
    conv3x3_pack #(.ABS_MODE(1)) u_abs (
        .pixel_clk(pixel_clk), .rst(rst), .in_valid(vin[1]),
        .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
        .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
        .wr_en(wen[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .done(dn[1]));
    conv3x3_pack #(.SHIFT(3)) u_sh (
        .pixel_clk(pixel_clk), .rst(rst), .in_valid(vin[2]),
        .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
        .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
        .wr_en(wen[2]), .wr_addr(wa[2]), .wr_data(wd[2]), .done(dn[2]));
    conv3x3_pack #(.IMG_W(4), .IMG_H(2), .WORDS_PER_ROW(2)) u_sm (
        .pixel_clk(pixel_clk), .rst(rst), .in_valid(vin[3]),
        .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
        .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
        .wr_en(wen[3]), .wr_addr(wa[3]), .wr_data(wd[3]), .done(dn[3]));

    // Capture every write of every instance, away from the active edge.
    always @(negedge pixel_clk) begin
        if (wen[0]) q0.push_back({wa[0], wd[0], dn[0], cyc});
        if (wen[1]) q1.push_back({wa[1], wd[1], dn[1], cyc});
        if (wen[2]) q2.push_back({wa[2], wd[2], dn[2], cyc});
        if (wen[3]) q3.push_back({wa[3], wd[3], dn[3], cyc});
        for (int i = 0; i < 4; i++) begin
            if (dn[i]) dn_cnt[i] = dn_cnt[i] + 1;
            if (dn[i] && !wen[i]) dn_alone = dn_alone + 1;
        end
    end

    task automatic pop_wr(input int d, output bit ok, output wr_t w);
        ok = 1'b0;
        w  = '0;
        case (d)
            0: if (q0.size() > 0) begin w = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin w = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin w = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin w = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic step(input logic [3:0] m, input logic [11:0] p1, p2, p3, k1, k2, k3);
        @(posedge pixel_clk); #1;
        vin = m; pixel1 = p1; pixel2 = p2; pixel3 = p3;
        kernel1 = k1; kernel2 = k2; kernel3 = k3;
    endtask

    // Identity kernel: the result equals the centre pixel.
    task automatic step_id(input logic [3:0] m, input logic [3:0] v);
        step(m, 12'h000, {4'h0, v, 4'h0}, 12'h000, IK1, IK2, IK3);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pixel_clk); #1; vin = '0; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        tot_cnt++; if ({wen[0], wa[0], wd[0], dn[0]} !== 31'd0) $display("FAIL reset_d0 got %h want 0", {wen[0], wa[0], wd[0], dn[0]}); else pass_cnt++;
        tot_cnt++; if ({wen[3], wa[3], wd[3], dn[3]} !== 31'd0) $display("FAIL reset_sm got %h want 0", {wen[3], wa[3], wd[3], dn[3]}); else pass_cnt++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_laplacian;
        int  t;
        bit  ok;
        wr_t w;
        repeat (3) step(4'b0001, 12'h555, 12'h555, 12'h555, LK1, LK2, LK3);
        t = cyc;
        idle(8);
        pop_wr(0, ok, w);
        tot_cnt++; if (!ok) $display("FAIL lap_write got none want 1"); else pass_cnt++;
        tot_cnt++; if (w.a !== 17'd0) $display("FAIL lap_addr got %0d want 0", w.a); else pass_cnt++;
        tot_cnt++; if (w.d !== 12'h000) $display("FAIL lap_data got %h want 000", w.d); else pass_cnt++;
        tot_cnt++; if (w.c !== 32'(t + 4)) $display("FAIL lap_latency got %0d want %0d", w.c, t + 4); else pass_cnt++;
    endtask

    task automatic test_abs_shift;
        bit  ok;
        wr_t w;
        step(4'b0111, 12'h000, 12'h0F0, 12'h000, LK1, LK2, LK3);
        step(4'b0111, 12'h333, 12'h303, 12'h333, LK1, LK2, LK3);
        step_id(4'b0111, 4'h5);
        idle(8);
        pop_wr(0, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd1 || w.d !== 12'h0F5) $display("FAIL clamp_plain got ok=%0d a=%0d d=%h want a=1 d=0f5", ok, w.a, w.d); else pass_cnt++;
        pop_wr(1, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd0 || w.d !== 12'hFF5) $display("FAIL clamp_abs got ok=%0d a=%0d d=%h want a=0 d=ff5", ok, w.a, w.d); else pass_cnt++;
        pop_wr(2, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd0 || w.d !== 12'h030) $display("FAIL clamp_shift got ok=%0d a=%0d d=%h want a=0 d=030", ok, w.a, w.d); else pass_cnt++;
    endtask

    task automatic test_bubbles;
        bit  ok;
        wr_t w;
        step_id(4'b0001, 4'h1);
        idle(2);
        step_id(4'b0001, 4'h2);
        idle(5);
        tot_cnt++; if (q0.size() !== 0) $display("FAIL bubble_early got %0d writes want 0", q0.size()); else pass_cnt++;
        step_id(4'b0001, 4'h3);
        idle(8);
        tot_cnt++; if (q0.size() !== 1) $display("FAIL bubble_count got %0d writes want 1", q0.size()); else pass_cnt++;
        pop_wr(0, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd2 || w.d !== 12'h123) $display("FAIL bubble_word got a=%0d d=%h want a=2 d=123", w.a, w.d); else pass_cnt++;
    endtask

    // Columns 9..637 streamed back-to-back, value = column mod 16.
    task automatic test_row_flush;
        bit          ok;
        wr_t         w;
        int          errs;
        int          n;
        logic [11:0] exp_d;
        for (int col = 9; col < 638; col++) step_id(4'b0001, 4'(col));
        idle(8);
        n = q0.size();
        tot_cnt++; if (n !== 210) $display("FAIL row_write_count got %0d want 210", n); else pass_cnt++;
        errs = 0;
        for (int j = 0; j < n; j++) begin
            pop_wr(0, ok, w);
            if (j < 209) exp_d = {4'(3*(j+3)), 4'(3*(j+3)+1), 4'(3*(j+3)+2)};
            else         exp_d = 12'hCD0;
            if (j == 0 && (w.a !== 17'd3 || w.d !== 12'h9AB)) errs++;
            if (j == n - 1) begin
                tot_cnt++; if (w.a !== 17'd212 || w.d !== 12'hCD0) $display("FAIL row_last got a=%0d d=%h want a=212 d=cd0", w.a, w.d); else pass_cnt++;
            end
            if (w.a !== 17'(j + 3) || w.d !== exp_d) errs++;
        end
        tot_cnt++; if (errs !== 0) $display("FAIL row_stream got %0d bad words want 0", errs); else pass_cnt++;
        step_id(4'b0001, 4'h1);
        step_id(4'b0001, 4'h2);
        step_id(4'b0001, 4'h3);
        idle(8);
        pop_wr(0, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd213 || w.d !== 12'h123) $display("FAIL row_next got ok=%0d a=%0d d=%h want a=213 d=123", ok, w.a, w.d); else pass_cnt++;
        tot_cnt++; if (dn_cnt[0] !== 0) $display("FAIL row_no_done got %0d want 0", dn_cnt[0]); else pass_cnt++;
    endtask

    task automatic test_small_frame;
        bit          ok;
        wr_t         w;
        logic [16:0] ea [4];
        logic [11:0] ed [4];
        logic        edn [4];
        ea = '{17'd0, 17'd1, 17'd2, 17'd3};
        ed = '{12'h123, 12'h400, 12'h567, 12'h800};
        edn = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int v = 1; v <= 8; v++) step_id(4'b1000, 4'(v));
        idle(8);
        for (int i = 0; i < 4; i++) begin
            pop_wr(3, ok, w);
            tot_cnt++; if (!ok || w.a !== ea[i] || w.d !== ed[i] || w.dn !== edn[i]) $display("FAIL frame_w%0d got ok=%0d a=%0d d=%h done=%0d want a=%0d d=%h done=%0d", i, ok, w.a, w.d, w.dn, ea[i], ed[i], edn[i]); else pass_cnt++;
        end
        tot_cnt++; if (dn_cnt[3] !== 1 || dn_alone !== 0) $display("FAIL frame_done got cnt=%0d alone=%0d want 1/0", dn_cnt[3], dn_alone); else pass_cnt++;
        // Next frame restarts at 0; then reset lands mid-row 1.
        for (int v = 9; v <= 12; v++) step_id(4'b1000, 4'(v));
        step_id(4'b1000, 4'h1);
        step_id(4'b1000, 4'h2);
        step_id(4'b1000, 4'h3);
        @(posedge pixel_clk); #1; vin = '0; rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(8);
        pop_wr(3, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd0 || w.d !== 12'h9AB) $display("FAIL frame2_w0 got ok=%0d a=%0d d=%h want a=0 d=9ab", ok, w.a, w.d); else pass_cnt++;
        pop_wr(3, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd1 || w.d !== 12'hC00) $display("FAIL frame2_w1 got ok=%0d a=%0d d=%h want a=1 d=c00", ok, w.a, w.d); else pass_cnt++;
        tot_cnt++; if (q3.size() !== 0 || dn_cnt[3] !== 1) $display("FAIL rst_abandon got writes=%0d dones=%0d want 0/1", q3.size(), dn_cnt[3]); else pass_cnt++;
        for (int v = 4; v <= 7; v++) step_id(4'b1000, 4'(v));
        idle(8);
        pop_wr(3, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd0 || w.d !== 12'h456) $display("FAIL post_rst_w0 got ok=%0d a=%0d d=%h want a=0 d=456", ok, w.a, w.d); else pass_cnt++;
        pop_wr(3, ok, w);
        tot_cnt++; if (!ok || w.a !== 17'd1 || w.d !== 12'h700 || w.dn !== 1'b0) $display("FAIL post_rst_w1 got ok=%0d a=%0d d=%h done=%0d want a=1 d=700 done=0", ok, w.a, w.d, w.dn); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_laplacian;
        test_abs_shift;
        test_bubbles;
        test_row_flush;
        test_small_frame;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
